// File: rtl/hd6309_dma_arbiter_if.sv
// Bus-sharing handshake between the HD6309 core, its clock wrapper and two DMA requesters.
// The arbiter uses the master modport; the core/requester side uses slave.
interface hd6309_dma_arbiter_if;
  logic [1:0] phase;
  logic       BA;
  logic       BS;
  logic [1:0] req;
  logic       nDMABREQ;
  logic [1:0] grant;
  logic       owner;
  logic       busy;

  modport master (
    input  phase, BA, BS, req,
    output nDMABREQ, grant, owner, busy
  );

  modport slave (
    output phase, BA, BS, req,
    input  nDMABREQ, grant, owner, busy
  );
endinterface

// File: rtl/hd6309_dma_arbiter.sv
// Shares the HD6309 bus between the CPU and two DMA requesters, sequenced on E-cycle
// boundaries, with round-robin tie breaking, a burst cap and a minimum release gap.
module hd6309_dma_arbiter #(
  parameter int unsigned MAX_BURST = 14,
  parameter int unsigned GAP       = 1
) (
  input  logic                 CLK4,
  input  logic                 nRESET,
  hd6309_dma_arbiter_if.master bus
);

  localparam int unsigned BURST_W = 4;
  localparam int unsigned GAP_W   = 2;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [BURST_W-1:0] BURST_SAT  = '1;
  localparam logic [GAP_W-1:0]   GAP_SAT    = '1;
  localparam logic [GAP_W:0]     GAP_MIN    = (GAP_W + 1)'(GAP);

  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

  state_t             state, state_n;
  logic               owner_q, owner_n;
  logic               last_q, last_n;
  logic [BURST_W-1:0] burst_q, burst_n;
  logic [GAP_W-1:0]   gap_q, gap_n;
  logic               nbreq_q, nbreq_n;
  logic [1:0]         grant_q, grant_n;
  logic               busy_q, busy_n;

  logic tick, released, req_own, end_grant;

  assign tick     = (bus.phase == 2'b11);
  assign released = bus.BA & bus.BS;
  assign req_own  = bus.req[owner_q];

  // State and registered outputs; reset clears grant asynchronously.
  always_ff @(posedge CLK4 or negedge nRESET) begin
    if (!nRESET) begin
      state   <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      burst_q <= '0;
      gap_q   <= '0;
      nbreq_q <= 1'b1;
      grant_q <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      owner_q <= owner_n;
      last_q  <= last_n;
      burst_q <= burst_n;
      gap_q   <= gap_n;
      nbreq_q <= nbreq_n;
      grant_q <= grant_n;
      busy_q  <= busy_n;
    end
  end

  // Next-state logic; only the bus-loss abort acts off the E-cycle tick.
  always_comb begin
    state_n   = state;
    owner_n   = owner_q;
    last_n    = last_q;
    burst_n   = burst_q;
    gap_n     = gap_q;
    nbreq_n   = nbreq_q;
    grant_n   = grant_q;
    busy_n    = busy_q;
    end_grant = 1'b0;

    case (state)
      IDLE: begin
        if (tick && (bus.req != 2'b00)) begin
          owner_n = (bus.req == 2'b11) ? ~last_q : bus.req[1];
          nbreq_n = 1'b0;
          busy_n  = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (tick) begin
          if (!req_own) begin
            nbreq_n = 1'b1;
            gap_n   = '0;
            state_n = RELEASE;
          end else if (released) begin
            grant_n = owner_q ? 2'b10 : 2'b01;
            burst_n = '0;
            state_n = GRANT;
          end
        end
      end
      GRANT: begin
        if (!released) begin
          end_grant = 1'b1;
        end else if (tick) begin
          if (burst_q != BURST_SAT) burst_n = burst_q + BURST_W'(1);
          if (!req_own || (burst_q == BURST_LAST)) end_grant = 1'b1;
        end
        if (end_grant) begin
          grant_n = 2'b00;
          nbreq_n = 1'b1;
          last_n  = owner_q;
          gap_n   = '0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (tick) begin
          if (gap_q != GAP_SAT) gap_n = gap_q + GAP_W'(1);
          // gap_q counts completed ticks, so gap_q+1 is the E cycles spent released
          if ((({1'b0, gap_q} + (GAP_W + 1)'(1)) >= GAP_MIN) && !bus.BA) begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.nDMABREQ = nbreq_q;
  assign bus.grant    = grant_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_hd6309_dma_arbiter.sv
// Randomized scoreboard bench for hd6309_dma_arbiter: a CPU model answers nDMABREQ with BA/BS,
// requester agents consume a demand in E cycles, and a monitor checks every grant against a queue.
module tb_hd6309_dma_arbiter;

  localparam int MAXB = 14;
  localparam int GAPC = 1;

  logic       CLK4 = 1'b0;
  logic       nRESET = 1'b0;
  logic [1:0] phase = 2'd0;
  logic       ba = 1'b0;
  logic       bs_kill = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  bit         cpu_en = 1'b1;
  int         cpu_lat = 2;

  int n_pass = 0;
  int n_total = 0;
  int inv_bad = 0;
  int n_rise = 0;
  int lo_model = 1;

  typedef struct {int owner; int len;} exp_t;
  exp_t sbq[$];

  hd6309_dma_arbiter_if ifc();

  assign ifc.phase = phase;
  assign ifc.BA    = ba;
  assign ifc.BS    = ba & ~bs_kill;
  assign ifc.req   = {req1, req0};

  hd6309_dma_arbiter #(.MAX_BURST(MAXB), .GAP(GAPC)) dut (
    .CLK4  (CLK4),
    .nRESET(nRESET),
    .bus   (ifc)
  );

  always #5 CLK4 = ~CLK4;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: serve remaining demand in E cycles, cap each grant, alternate on ties.
  task automatic push_round(input int d0, input int d1);
    int rem[2];
    int pick;
    int seg;
    rem[0] = d0;
    rem[1] = d1;
    while (rem[0] > 0 || rem[1] > 0) begin
      if (rem[0] > 0 && rem[1] > 0) pick = 1 - lo_model;
      else pick = (rem[0] > 0) ? 0 : 1;
      seg = (rem[pick] < MAXB) ? rem[pick] : MAXB;
      sbq.push_back('{pick, 4 * seg});
      rem[pick] -= seg;
      lo_model = pick;
    end
  endtask

  // Phase counter and CPU: BA/BS follow a low nDMABREQ after cpu_lat E cycles.
  initial begin : cpu_model
    int dn;
    dn = 0;
    forever begin
      @(negedge CLK4);
      phase = phase + 2'd1;
      if (phase == 2'd0) begin
        if (cpu_en && !ifc.nDMABREQ) begin
          if (dn < 15) dn++;
          if (dn >= cpu_lat) ba = 1'b1;
        end else begin
          dn = 0;
          ba = 1'b0;
        end
      end
    end
  end

  // Monitor: measure each grant pulse and compare against the scoreboard.
  initial begin : monitor
    logic [1:0] g_prev;
    logic [1:0] g_rise;
    logic       own_rise;
    int         len;
    int         low;
    bit         seen;
    exp_t       e;
    g_prev = 2'b00; g_rise = 2'b00; own_rise = 1'b0;
    len = 0; low = 0; seen = 1'b0;
    forever begin
      @(posedge CLK4);
      #1;
      if (ifc.grant == 2'b11) inv_bad++;
      if (ifc.grant != 2'b00 && (ifc.nDMABREQ || !ifc.busy)) inv_bad++;
      if (!ifc.nDMABREQ && !ifc.busy) inv_bad++;
      if (ifc.grant != 2'b00 && g_prev != 2'b00 && ifc.grant != g_prev) inv_bad++;
      if (ifc.grant != 2'b00 && g_prev == 2'b00) begin
        n_rise++;
        if (seen) check("gap_before_grant", int'(low >= 4 * GAPC), 1);
        check("grant_start_phase", int'(phase), 3);
        g_rise = ifc.grant;
        own_rise = ifc.owner;
        len = 0;
      end
      if (ifc.grant != 2'b00) len++;
      else if (g_prev != 2'b00) begin
        seen = 1'b1;
        low = 0;
        check("grant_expected", int'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("grant_bits", int'(g_rise), 1 << e.owner);
          check("grant_owner", int'(own_rise), e.owner);
          check("grant_len", len, e.len);
        end
      end
      if (ifc.grant == 2'b00) low++;
      g_prev = ifc.grant;
    end
  end

  task automatic wait_nbreq(input logic val, input int limit, output int cnt);
    cnt = 0;
    do begin
      @(posedge CLK4);
      #1;
      cnt++;
    end while (ifc.nDMABREQ != val && cnt < limit);
  endtask

  task automatic wait_grant(input int limit, output int cnt);
    cnt = 0;
    do begin
      @(posedge CLK4);
      #1;
      cnt++;
    end while (ifc.grant == 2'b00 && cnt < limit);
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    while (ifc.busy && g < 400) begin
      @(posedge CLK4);
      #1;
      g++;
    end
    check(name, int'(ifc.busy), 0);
  endtask

  // Posedges from now (just after a negedge) until the next tick edge.
  function automatic int edges_to_tick();
    logic [1:0] t;
    t = 2'd3 - phase;
    return int'(t) + 1;
  endfunction

  // Requester: holds req until it has held grant for d E cycles in total.
  task automatic agent(input int i, input int d);
    int hi;
    int g;
    hi = 0;
    g = 0;
    if (d > 0) begin
      while (g < 4000 && (i == 0 ? req0 : req1)) begin
        @(posedge CLK4);
        #1;
        g++;
        if (ifc.grant[i] && ++hi == 4 * (d - 1) + 1) begin
          if (i == 0) req0 = 1'b0; else req1 = 1'b0;
        end
      end
      check("agent_done_in_budget", int'(g < 4000), 1);
      if (i == 0) req0 = 1'b0; else req1 = 1'b0;
    end
  endtask

  task automatic run_round(input int d0, input int d1, input int lat);
    int k;
    cpu_lat = lat;
    push_round(d0, d1);
    @(negedge CLK4);
    #1;
    k = edges_to_tick();
    if (d0 > 0) req0 = 1'b1;
    if (d1 > 0) req1 = 1'b1;
    fork
      agent(0, d0);
      agent(1, d1);
      begin
        int c1;
        int c2;
        wait_nbreq(1'b0, 8, c1);
        check("nbreq_fall_latency", c1, k);
        wait_grant(100, c2);
        check("grant_latency", c2, 4 * lat);
      end
    join
    wait_idle("round_idle");
    check("scoreboard_drained", sbq.size(), 0);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time budget exceeded");
    $fatal(1);
  end

  initial begin : main
    int k;
    int c;
    int rises;
    int m;
    int d0;
    int d1;

    // Reset values.
    repeat (2) @(negedge CLK4);
    check("reset_nbreq", int'(ifc.nDMABREQ), 1);
    check("reset_grant", int'(ifc.grant), 0);
    check("reset_owner", int'(ifc.owner), 0);
    check("reset_busy", int'(ifc.busy), 0);
    nRESET = 1'b1;
    repeat (4) @(negedge CLK4);

    // Single grant of 3 E cycles, then burst cap, then round robin.
    run_round(3, 0, 2);
    run_round(0, MAXB + 2, 2);
    run_round(2 * MAXB, 2 * MAXB, 1);

    // Withdraw while waiting for the bus.
    cpu_en = 1'b0;
    rises = n_rise;
    @(negedge CLK4);
    #1;
    k = edges_to_tick();
    req0 = 1'b1;
    wait_nbreq(1'b0, 8, c);
    check("wreq_nbreq_fall", c, k);
    repeat (8) @(posedge CLK4);
    @(negedge CLK4);
    #1;
    k = edges_to_tick();
    req0 = 1'b0;
    wait_nbreq(1'b1, 8, c);
    check("wreq_nbreq_rise", c, k);
    wait_idle("wreq_idle");
    check("wreq_no_grant", n_rise - rises, 0);
    cpu_en = 1'b1;
    repeat (4) @(negedge CLK4);

    // Bus loss in the middle of the 5th E cycle of a grant.
    cpu_lat = 2;
    sbq.push_back('{0, 19});
    @(negedge CLK4);
    #1;
    req0 = 1'b1;
    wait_grant(100, c);
    check("abort_grant_seen", int'(ifc.grant != 2'b00), 1);
    repeat (18) @(posedge CLK4);
    @(negedge CLK4);
    bs_kill = 1'b1;
    req0 = 1'b0;
    @(posedge CLK4);
    #1;
    check("abort_grant", int'(ifc.grant), 0);
    check("abort_nbreq", int'(ifc.nDMABREQ), 1);
    wait_idle("abort_idle");
    bs_kill = 1'b0;
    sbq.push_back('{1, 4});
    @(negedge CLK4);
    #1;
    req0 = 1'b1;
    req1 = 1'b1;
    wait_grant(100, c);
    check("abort_next_owner", int'(ifc.owner), 1);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle("abort_tie_idle");
    check("abort_drained", sbq.size(), 0);
    lo_model = 1;

    // Asynchronous reset in the middle of a grant.
    sbq.push_back('{0, 6});
    @(negedge CLK4);
    #1;
    req0 = 1'b1;
    wait_grant(100, c);
    repeat (5) @(posedge CLK4);
    #2;
    nRESET = 1'b0;
    #1;
    check("rst_grant", int'(ifc.grant), 0);
    check("rst_nbreq", int'(ifc.nDMABREQ), 1);
    check("rst_busy", int'(ifc.busy), 0);
    req0 = 1'b0;
    #1;
    nRESET = 1'b1;
    lo_model = 1;
    repeat (8) @(posedge CLK4);
    run_round(1, 1, $urandom_range(1, 3));

    // Randomized rounds.
    for (int r = 0; r < 16; r++) begin
      m  = $urandom_range(1, 3);
      d0 = (m != 2) ? $urandom_range(1, 2 * MAXB + 3) : 0;
      d1 = (m != 1) ? $urandom_range(1, 2 * MAXB + 3) : 0;
      run_round(d0, d1, $urandom_range(1, 3));
    end

    check("invariant_violations", inv_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hd6309_dma_arbiter.md
# hd6309_dma_arbiter

Bus-request arbiter that shares the HD6309 system bus between the CPU core and two DMA requesters (for example video refresh and disk DMA). It drives the core's nDMABREQ, watches the core's BA/BS bus-grant status, and issues a one-hot grant to exactly one requester while the CPU has released the bus. All sequencing is aligned to E-cycle boundaries, using the 2-bit phase counter produced by the clock-generation wrapper. It enforces a maximum burst length so the CPU is never starved.

## Interface
- MAX_BURST, 14: maximum E cycles a requester keeps the bus per grant; legal range 1..15.
- GAP, 1: minimum E cycles with nDMABREQ high between two grants; legal range 1..3.
- CLK4  in  1  4x bus clock, rising-edge; the only clock.
- nRESET  in  1  asynchronous, active-low reset.
- phase  in  2  wrapper's clk4_cnt; 2'b11 marks the last quarter of an E cycle.
- BA  in  1  core bus-available status.
- BS  in  1  core bus-status.
- req  in  2  level requests; req[0] and req[1] are held high until served or withdrawn.
- nDMABREQ  out  1  to core, active-low DMA/bus request.
- grant  out  2  one-hot bus grant to the requesters; the requester may drive ADDR/D/RnW only while its bit is high.
- owner  out  1  index of the current or pending owner; valid when busy=1.
- busy  out  1  high in every state except IDLE.

## Operation
- Tick: tick = (phase == 2'b11). All state and output changes happen on the CLK4 rising edge where tick=1, except the asynchronous reset and the BA/BS-loss abort.
- Bus released: released = BA & BS.
- Registers: state, owner, last_owner, burst_cnt (4 bits), gap_cnt (2 bits). All outputs are registered.
- IDLE:
  - If req == 2'b00, stay in IDLE.
  - Otherwise pick the new owner. If only one request is high, pick it. If both are high, pick ~last_owner (round robin).
  - On the same edge, set nDMABREQ to 0 and go to REQ.
- REQ:
  - If req[owner] = 0 (withdrawn), set nDMABREQ to 1, set gap_cnt to 0 and go to RELEASE.
  - Else if released = 1, set grant[owner] to 1, set burst_cnt to 0 and go to GRANT.
  - Otherwise wait in REQ; there is no timeout.
- GRANT:
  - On each tick, increment burst_cnt.
  - End the grant if req[owner] = 0 or burst_cnt == MAX_BURST-1.
  - On ending: set grant to 00, set nDMABREQ to 1, set last_owner to owner, set gap_cnt to 0 and go to RELEASE.
- Abort: in GRANT, if released drops to 0 at any CLK4 edge (tick or not), clear grant on that edge, set nDMABREQ to 1, set last_owner to owner and go to RELEASE.
- RELEASE:
  - On each tick, increment gap_cnt.
  - Go to IDLE on the tick where gap_cnt >= GAP-1 and BA = 0.
  - Any req seen in RELEASE waits for IDLE.
- Invariants:
  - grant is never 2'b11.
  - grant != 0 implies nDMABREQ = 0 and state = GRANT.
  - owner changes only in IDLE.
- burst_cnt saturates at 15 and does not wrap.

## Timing
- Reset (asynchronous, while nRESET = 0):
  - nDMABREQ = 1, grant = 2'b00, owner = 0, busy = 0.
  - state = IDLE, last_owner = 1, so req[0] wins the first tie.
  - burst_cnt = 0, gap_cnt = 0.
- Reset mid-grant: grant drops immediately, asynchronously, with no glitch on the other bit.
- Request latency:
  - req rises, then nDMABREQ falls at the next tick edge.
  - grant rises at the first tick edge after released = 1 is seen.
  - Every grant starts on a phase 11→00 boundary, i.e. at the start of an E cycle.
- Grant length: a grant lasts exactly MAX_BURST full E cycles (4*MAX_BURST CLK4 cycles) unless the requester withdraws or the bus is lost.
- Requester withdrawal: dropping req[owner] in GRANT ends the grant at the next tick edge. The current E cycle is completed.
- Gap: the minimum number of nDMABREQ-high E cycles between two grants is GAP.
- busy: rises with nDMABREQ and falls on entry to IDLE.

## Test plan
- Single grant: req=01 held, with BA/BS following nDMABREQ after 2 E cycles.
  - nDMABREQ falls at the first tick; grant=01 begins 2 E cycles later.
  - Requester drops req after 3 E cycles → grant is high for exactly 12 CLK4 cycles.
- Burst cap: req=10 held continuously, MAX_BURST=14.
  - grant=10 lasts exactly 56 CLK4 cycles, then nDMABREQ is high for GAP E cycles, then a re-request is issued.
- Round robin: req=11 held.
  - The grant sequence is 01, 10, 01, 10.
  - Every grant change is separated by at least GAP E cycles with grant=00.
- Withdraw in REQ: req=01, BA held 0, req dropped after 2 E cycles.
  - nDMABREQ returns to 1 at the next tick, grant never asserts, and the block returns to IDLE.
- Bus loss: force BS=0 in the middle of the 5th E cycle of a GRANT.
  - grant=00 and nDMABREQ=1 on that same CLK4 edge.
  - Next tie is won by the other requester.
- Reset mid-grant: nRESET pulsed low between clock edges during GRANT.
  - grant=00, nDMABREQ=1, busy=0 immediately.
  - After release, req=11 grants 01 first.
